// File: rtl/conv_seq_pkg.sv
// Shared types and sizing for the conv1 frame sequencer.
// Counter widths are derived from the frame geometry.
package conv_seq_pkg;

    localparam int IMG_W       = 28;
    localparam int IMG_H       = 28;
    localparam int KSIZE       = 3;
    localparam int CLR_CYCLES  = 2;
    localparam int FRAME_CNT_W = 5;
    localparam int TIMEOUT_CYC = 4096;

    localparam int PIX_PER_FRAME = IMG_W * IMG_H;
    localparam int OUT_PER_FRAME =
        (IMG_W - KSIZE + 1) * (IMG_H - KSIZE + 1);

    localparam int PIX_CNT_W = $clog2(PIX_PER_FRAME + 1);
    localparam int OUT_CNT_W = $clog2(OUT_PER_FRAME + 1);
    localparam int CLR_CNT_W = $clog2(CLR_CYCLES + 1);
    localparam int TO_CNT_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FEED,
        DRAIN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/conv_seq_counter.sv
// Loadable saturating up-counter with a terminal-count flag.
// tc_o is high while the count equals MAX.
module conv_seq_counter #(
    parameter int          W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         en_i,
    output logic [W-1:0] q_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o  = cnt_q;
    assign tc_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/conv_frame_sequencer.sv
// Batch controller: clears conv1, streams a frame, drains its results.
// Optional drain watchdog: define CONV_TIMEOUT_EN.
module conv_frame_sequencer
    import conv_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [FRAME_CNT_W-1:0] num_frames,
    input  logic                   pix_valid,
    input  logic [15:0]            pix_data,
    output logic                   pix_ready,
    output logic                   conv_reset_n,
    output logic                   conv_rdata_r,
    output logic [15:0]            conv_data_in,
    input  logic                   conv_wdata_r,
    input  logic [31:0]            conv_data_out,
    output logic                   out_valid,
    output logic [31:0]            out_data,
    output logic                   out_last,
    output logic [FRAME_CNT_W-1:0] out_frame,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    seq_state_e             state_q;
    logic [FRAME_CNT_W-1:0] num_frames_q;
    logic [FRAME_CNT_W-1:0] frame_idx_q;
    logic                   conv_reset_n_q;
    logic                   conv_rdata_r_q;
    logic [15:0]            conv_data_in_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   out_valid_q;
    logic [31:0]            out_data_q;
    logic                   out_last_q;
    logic [FRAME_CNT_W-1:0] out_frame_q;

    logic [PIX_CNT_W-1:0]   pix_cnt;
    logic [OUT_CNT_W-1:0]   out_cnt;
    logic [CLR_CNT_W-1:0]   clr_cnt;
    logic                   pix_tc;
    logic                   out_tc;
    logic                   clr_tc;

    logic xfer;
    logic wdata_acc;
    logic last_frame;
    logic out_full;
    logic timeout;
    logic frame_done;
    logic enter_clr;

    assign pix_ready  = (state_q == FEED);
    assign xfer       = pix_valid && (state_q == FEED);
    assign wdata_acc  = conv_wdata_r &&
                        ((state_q == FEED) ||
                         (state_q == DRAIN) ||
                         (state_q == DONE));
    assign last_frame = (frame_idx_q == num_frames_q - 1'b1);
    assign out_full   = (out_cnt >= OUT_CNT_W'(OUT_PER_FRAME));
    assign frame_done = (state_q == DRAIN) && (out_full || timeout);
    assign enter_clr  = ((state_q == IDLE) && start &&
                         (num_frames != '0)) ||
                        (frame_done && !last_frame);

    conv_seq_counter #(
        .W   (PIX_CNT_W),
        .MAX (PIX_PER_FRAME - 1)
    ) u_pix_cnt (
        .clk      (clk),
        .rst_n    (reset_n),
        .ld_i     (enter_clr),
        .ld_val_i ('0),
        .en_i     (xfer),
        .q_o      (pix_cnt),
        .tc_o     (pix_tc)
    );

    conv_seq_counter #(
        .W   (OUT_CNT_W),
        .MAX (OUT_PER_FRAME - 1)
    ) u_out_cnt (
        .clk      (clk),
        .rst_n    (reset_n),
        .ld_i     (enter_clr),
        .ld_val_i ('0),
        .en_i     (wdata_acc),
        .q_o      (out_cnt),
        .tc_o     (out_tc)
    );

    // Held at zero outside CLR so every clear window starts fresh.
    conv_seq_counter #(
        .W   (CLR_CNT_W),
        .MAX (CLR_CYCLES - 1)
    ) u_clr_cnt (
        .clk      (clk),
        .rst_n    (reset_n),
        .ld_i     (state_q != CLR),
        .ld_val_i ('0),
        .en_i     (state_q == CLR),
        .q_o      (clr_cnt),
        .tc_o     (clr_tc)
    );

    logic unused_cnt;
    assign unused_cnt = ^{pix_cnt, clr_cnt};

`ifdef CONV_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;
    logic                to_tc;
    logic                err_q;

    conv_seq_counter #(
        .W   (TO_CNT_W),
        .MAX (TIMEOUT_CYC - 1)
    ) u_to_cnt (
        .clk      (clk),
        .rst_n    (reset_n),
        .ld_i     (state_q != DRAIN),
        .ld_val_i ('0),
        .en_i     (state_q == DRAIN),
        .q_o      (to_cnt),
        .tc_o     (to_tc)
    );

    logic unused_to;
    assign unused_to = ^to_cnt;
    assign timeout   = (state_q == DRAIN) && to_tc && !out_full;
    assign err       = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            num_frames_q   <= '0;
            frame_idx_q    <= '0;
            conv_reset_n_q <= 1'b1;
            conv_rdata_r_q <= 1'b0;
            conv_data_in_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef CONV_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
        end else begin
            done_q         <= 1'b0;
            conv_rdata_r_q <= xfer;
            if (xfer) begin
                conv_data_in_q <= pix_data;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        num_frames_q <= num_frames;
                        frame_idx_q  <= '0;
                        busy_q       <= 1'b1;
`ifdef CONV_TIMEOUT_EN
                        err_q        <= 1'b0;
`endif
                        if (num_frames == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q        <= CLR;
                            conv_reset_n_q <= 1'b0;
                        end
                    end
                end
                CLR: begin
                    if (clr_tc) begin
                        conv_reset_n_q <= 1'b1;
                        state_q        <= FEED;
                    end
                end
                FEED: begin
                    if (xfer && pix_tc) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
`ifdef CONV_TIMEOUT_EN
                    if (timeout) begin
                        err_q <= 1'b1;
                    end
`endif
                    if (frame_done) begin
                        if (last_frame) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            frame_idx_q    <= frame_idx_q + 1'b1;
                            state_q        <= CLR;
                            conv_reset_n_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Result path registers ahead of the FSM, so the last result
    // still leaves even when DRAIN exits on the following edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_frame_q <= '0;
        end else begin
            out_valid_q <= wdata_acc;
            out_last_q  <= wdata_acc && out_tc;
            if (wdata_acc) begin
                out_data_q  <= conv_data_out;
                out_frame_q <= frame_idx_q;
            end
        end
    end

    assign conv_reset_n = conv_reset_n_q;
    assign conv_rdata_r = conv_rdata_r_q;
    assign conv_data_in = conv_data_in_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign out_frame    = out_frame_q;

endmodule
